// File: rtl/axis_norm_rr_arbiter.sv
// Round-robin, packet-locked AXI-Stream arbiter feeding the Norm-path broadcaster.
// A grant holds until TLAST or MAX_BEATS accepted beats; the output stage is a single register slice.
module axis_norm_rr_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int DATA_W    = 128,
  parameter int MAX_BEATS = 256,
  parameter int ID_W      = 2
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_SRC-1:0]        S_AXIS_TVALID,
  output logic [NUM_SRC-1:0]        S_AXIS_TREADY,
  input  logic [NUM_SRC*DATA_W-1:0] S_AXIS_TDATA,
  input  logic [NUM_SRC-1:0]        S_AXIS_TLAST,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic [DATA_W-1:0]         M_AXIS_TDATA,
  output logic                      M_AXIS_TLAST,
  output logic [ID_W-1:0]           M_AXIS_TID,
  output logic                      busy,
  output logic                      ovf_err
);

  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);
  localparam logic [SEL_W-1:0] TOP_SRC  = SEL_W'(NUM_SRC - 1);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t              state_q;
  logic [SEL_W-1:0]    grant_q;
  logic [SEL_W-1:0]    lastGrant_q;
  logic [CNT_W-1:0]    beatCnt_q;
  logic                outValid_q;
  logic [DATA_W-1:0]   outData_q;
  logic                outLast_q;
  logic [ID_W-1:0]     outTid_q;
  logic                busy_q;
  logic                ovfErr_q;

  logic                canLoad;
  logic                accept;
  logic [DATA_W-1:0]   selData;
  logic                selLast;
  logic                pickValid_d;
  logic [SEL_W-1:0]    grant_d;
  logic [SEL_W-1:0]    cand;

  // Ready only depends on state and downstream ready, never on TVALID.
  assign canLoad = !outValid_q || M_AXIS_TREADY;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_ready
    assign S_AXIS_TREADY[i] = (state_q == LOCK) && (grant_q == SEL_W'(i)) && canLoad;
  end

  assign accept = |(S_AXIS_TVALID & S_AXIS_TREADY);

  always_comb begin
    selData = '0;
    selLast = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == SEL_W'(i)) begin
        selData = S_AXIS_TDATA[i*DATA_W +: DATA_W];
        selLast = S_AXIS_TLAST[i];
      end
    end
  end

  // Search starts just after the last granted source and wraps modulo NUM_SRC.
  always_comb begin
    pickValid_d = 1'b0;
    grant_d     = lastGrant_q;
    cand        = lastGrant_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = (cand == TOP_SRC) ? '0 : cand + SEL_W'(1);
      if (!pickValid_d && S_AXIS_TVALID[cand]) begin
        pickValid_d = 1'b1;
        grant_d     = cand;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      lastGrant_q <= TOP_SRC;
      beatCnt_q   <= '0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outLast_q   <= 1'b0;
      outTid_q    <= '0;
      busy_q      <= 1'b0;
      ovfErr_q    <= 1'b0;
    end else begin
      if (accept) begin
        outValid_q <= 1'b1;
        outData_q  <= selData;
        outLast_q  <= selLast;
        outTid_q   <= ID_W'(grant_q);
      end else if (M_AXIS_TREADY) begin
        outValid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (pickValid_d) begin
            grant_q <= grant_d;
            state_q <= LOCK;
            busy_q  <= 1'b1;
          end
        end
        LOCK: begin
          if (accept) begin
            // A forced release at MAX_BEATS keeps the beat's own TLAST untouched.
            if (selLast || (beatCnt_q == LAST_CNT)) begin
              if (!selLast) begin
                ovfErr_q <= 1'b1;
              end
              lastGrant_q <= grant_q;
              beatCnt_q   <= '0;
              state_q     <= IDLE;
              busy_q      <= 1'b0;
            end else begin
              beatCnt_q <= beatCnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign M_AXIS_TVALID = outValid_q;
  assign M_AXIS_TDATA  = outData_q;
  assign M_AXIS_TLAST  = outLast_q;
  assign M_AXIS_TID    = outTid_q;
  assign busy          = busy_q;
  assign ovf_err       = ovfErr_q;

endmodule

// File: tb/tb_axis_norm_rr_arbiter.sv
// Directed bench for axis_norm_rr_arbiter: arbitration order, stalls, forced release and async reset.
// Each source replays a numbered beat stream so every expected output beat is known from the cycle index.
module tb_axis_norm_rr_arbiter;

  localparam int NS = 4;
  localparam int DW = 128;
  localparam int MB = 4;
  localparam int IW = 2;

  logic             aclk = 1'b0;
  logic             areset;
  logic [NS-1:0]    sValid;
  logic [NS-1:0]    sReady;
  logic [NS*DW-1:0] sData;
  logic [NS-1:0]    sLast;
  logic             mValid;
  logic             mReady;
  logic [DW-1:0]    mData;
  logic             mLast;
  logic [IW-1:0]    mTid;
  logic             busy;
  logic             ovfErr;

  int   checks   = 0;
  int   failures = 0;
  int   total  [NS];
  int   sent   [NS];
  int   pktLen [NS];
  int   tag;
  logic mReadyCfg;

  axis_norm_rr_arbiter #(
    .NUM_SRC  (NS),
    .DATA_W   (DW),
    .MAX_BEATS(MB),
    .ID_W     (IW)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .S_AXIS_TVALID(sValid),
    .S_AXIS_TREADY(sReady),
    .S_AXIS_TDATA (sData),
    .S_AXIS_TLAST (sLast),
    .M_AXIS_TVALID(mValid),
    .M_AXIS_TREADY(mReady),
    .M_AXIS_TDATA (mData),
    .M_AXIS_TLAST (mLast),
    .M_AXIS_TID   (mTid),
    .busy         (busy),
    .ovf_err      (ovfErr)
  );

  always #5 aclk = ~aclk;

  function automatic logic [DW-1:0] mkData(int t, int s, int n);
    return {32'hC0DE0000 | 32'(t), 32'(s), 32'(n), 32'hA5A5A5A5};
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Present each source's next unsent beat; pktLen 0 means the stream never asserts TLAST.
  task automatic applyStimulus();
    for (int i = 0; i < NS; i++) begin
      if (sent[i] < total[i]) begin
        sValid[i]           = 1'b1;
        sData[i*DW +: DW]   = mkData(tag, i, sent[i]);
        sLast[i]            = (pktLen[i] != 0) && ((sent[i] % pktLen[i]) == pktLen[i] - 1);
      end else begin
        sValid[i]           = 1'b0;
        sData[i*DW +: DW]   = '0;
        sLast[i]            = 1'b0;
      end
    end
    mReady = mReadyCfg;
  endtask

  task automatic tick();
    logic [NS-1:0] acc;
    acc = sValid & sReady;
    @(posedge aclk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (acc[i]) sent[i]++;
    end
    applyStimulus();
    #1;
  endtask

  task automatic doReset();
    areset = 1'b1;
    for (int i = 0; i < NS; i++) begin
      total[i]  = 0;
      sent[i]   = 0;
      pktLen[i] = 0;
    end
    mReadyCfg = 1'b1;
    applyStimulus();
    @(posedge aclk);
    #1;
    checkOutput("rst.tvalid", mValid, 0);
    checkOutput("rst.tdata", mData, 0);
    checkOutput("rst.tlast", mLast, 0);
    checkOutput("rst.tid", mTid, 0);
    checkOutput("rst.sready", sReady, 0);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.ovf", ovfErr, 0);
  endtask

  task automatic releaseReset();
    areset = 1'b0;
    applyStimulus();
    #1;
  endtask

  // Back-to-back packets of length L with M ready held high: packet p is busy on
  // cycles 1+(L+1)p .. L+(L+1)p and appears on the output one cycle later.
  task automatic checkSeq(input string name, input int seq [8], input int n, input int L);
    logic          expValid, expLast, expBusy;
    logic [DW-1:0] expData;
    logic [NS-1:0] expRdy;
    int            expTid, r, p, b, s, q;
    for (int c = 0; c <= (L + 1) * n + 1; c++) begin
      expValid = 1'b0; expLast = 1'b0; expBusy = 1'b0;
      expData = '0; expRdy = '0; expTid = 0;
      if (c >= 2) begin
        r = c - 2; p = r / (L + 1); b = r % (L + 1);
        if (p < n && b < L) begin
          s = seq[p]; q = 0;
          for (int j = 0; j < p; j++) if (seq[j] == s) q++;
          expValid = 1'b1;
          expData  = mkData(tag, s, q * L + b);
          expLast  = (b == L - 1);
          expTid   = s;
        end
      end
      if (c >= 1) begin
        r = c - 1; p = r / (L + 1); b = r % (L + 1);
        if (p < n && b < L) begin
          expBusy = 1'b1;
          expRdy  = NS'(1) << seq[p];
        end
      end
      checkOutput($sformatf("%s.tvalid.c%0d", name, c), mValid, expValid);
      if (expValid) begin
        checkOutput($sformatf("%s.tdata.c%0d", name, c), mData, expData);
        checkOutput($sformatf("%s.tlast.c%0d", name, c), mLast, expLast);
        checkOutput($sformatf("%s.tid.c%0d", name, c), mTid, expTid);
      end
      checkOutput($sformatf("%s.busy.c%0d", name, c), busy, expBusy);
      checkOutput($sformatf("%s.sready.c%0d", name, c), sReady, expRdy);
      tick();
    end
  endtask

  int seqA [8];
  int idx3 [12] = '{-1, -1, 0, 1, 1, 1, 1, 1, 1, 2, 3, -1};
  int rdy3 [12] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0};
  int idx4 [11] = '{-1, -1, 0, 1, 2, 3, -1, 4, 5, -1, -1};
  int bsy4 [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
  int ovf4 [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  initial begin
    areset    = 1'b1;
    mReadyCfg = 1'b1;
    tag       = 0;

    // Two sources, alternating 3-beat packets with one idle cycle between them.
    doReset();
    tag = 1;
    total[0] = 12; pktLen[0] = 3;
    total[1] = 12; pktLen[1] = 3;
    releaseReset();
    seqA = '{0, 1, 0, 1, 0, 1, 0, 1};
    checkSeq("alt", seqA, 8, 3);

    // Sources 2 and 0 only: 0 wins first, then 2, then back to 0.
    doReset();
    tag = 2;
    total[0] = 4; pktLen[0] = 2;
    total[2] = 2; pktLen[2] = 2;
    releaseReset();
    seqA = '{0, 2, 0, 0, 0, 0, 0, 0};
    checkSeq("rr", seqA, 3, 2);

    // Downstream stall for 5 cycles on a MAX_BEATS-long packet ending in TLAST.
    doReset();
    tag = 3;
    total[1] = 4; pktLen[1] = 4;
    releaseReset();
    for (int c = 0; c < 12; c++) begin
      checkOutput($sformatf("stall.tvalid.c%0d", c), mValid, idx3[c] >= 0);
      if (idx3[c] >= 0) begin
        checkOutput($sformatf("stall.tdata.c%0d", c), mData, mkData(3, 1, idx3[c]));
        checkOutput($sformatf("stall.tlast.c%0d", c), mLast, idx3[c] == 3);
        checkOutput($sformatf("stall.tid.c%0d", c), mTid, 1);
      end
      checkOutput($sformatf("stall.sready.c%0d", c), sReady, rdy3[c] != 0 ? 4'b0010 : 4'b0000);
      checkOutput($sformatf("stall.ovf.c%0d", c), ovfErr, 0);
      mReadyCfg = !((c + 1) >= 3 && (c + 1) <= 7);
      tick();
    end

    // Six beats with no TLAST: forced release after beat 4, sticky overflow, regrant, then
    // the source goes quiet while still locked.
    doReset();
    tag = 4;
    total[1] = 6; pktLen[1] = 0;
    releaseReset();
    for (int c = 0; c < 11; c++) begin
      checkOutput($sformatf("ovf.tvalid.c%0d", c), mValid, idx4[c] >= 0);
      if (idx4[c] >= 0) begin
        checkOutput($sformatf("ovf.tdata.c%0d", c), mData, mkData(4, 1, idx4[c]));
        checkOutput($sformatf("ovf.tlast.c%0d", c), mLast, 0);
        checkOutput($sformatf("ovf.tid.c%0d", c), mTid, 1);
      end
      checkOutput($sformatf("ovf.busy.c%0d", c), busy, bsy4[c]);
      checkOutput($sformatf("ovf.flag.c%0d", c), ovfErr, ovf4[c]);
      tick();
    end

    // Asynchronous reset in the middle of a 5-beat packet, then clean restart.
    doReset();
    tag = 5;
    total[0] = 5; pktLen[0] = 5;
    releaseReset();
    tick(); tick(); tick();
    checkOutput("arst.pre.tdata", mData, mkData(5, 0, 1));
    checkOutput("arst.pre.busy", busy, 1);
    #1;
    areset = 1'b1;
    #1;
    checkOutput("arst.tvalid", mValid, 0);
    checkOutput("arst.busy", busy, 0);
    checkOutput("arst.sready", sReady, 0);
    checkOutput("arst.tdata", mData, 0);
    doReset();
    tag = 6;
    total[0] = 4; pktLen[0] = 2;
    total[1] = 4; pktLen[1] = 2;
    releaseReset();
    seqA = '{0, 1, 0, 1, 0, 0, 0, 0};
    checkSeq("post", seqA, 4, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
